// File: rtl/fnd_digit_decoder.sv
// fnd_digit_decoder
// Scan-side decoder for a multiplexed 7-segment display. It registers the scan
// index from the digit-select counter and drives the active-low common lines
// and the active-low {dp,g,f,e,d,c,b,a} bus for the addressed digit.
// New digit sets arrive through a valid/ready handshake into a shadow buffer.
// The shadow buffer is promoted to the displayed buffer only at a frame
// boundary, so a frame never mixes old and new digits.
// A frame counter drives the blink phase for the per-digit dp blink.
//
// Optional build macro: FND_LZ_BLANK_EN enables leading-zero blanking of the
// displayed value. Digit 0 is never blanked. Without the macro every digit is
// always decoded.
//
// Handshake: a transfer happens on a rising clk edge where load_valid and
// load_ready are both 1. After a transfer load_ready stays 0 until the shadow
// buffer is promoted. The source must hold load_valid and the load_* data
// stable until the transfer happens. Inputs offered while load_ready is 0 are
// ignored.

module fnd_digit_decoder #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_WIDTH-1:0]    digit_sel,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blink,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [7:0]              fnd_data,
  output logic                    frame_done
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Shadow buffer occupancy.
  typedef enum logic {
    SH_EMPTY = 1'b0,
    SH_FULL  = 1'b1
  } sh_state_t;

  sh_state_t sh_state_q, sh_state_d;

  // Scan index pipeline.
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] sel_prev_q, sel_prev_d;

  // Shadow and displayed digit buffers.
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_blink_q, shadow_blink_d;
  logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blink_q, disp_blink_d;

  // Blink timing.
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             phase_q, phase_d;

  // Registered display outputs.
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic [7:0]            data_q, data_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  logic [NUM_DIGITS-1:0] lz_mask;

  // Hex nibble to active-low segment pattern, dp off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    s = 8'hFF;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // A frame starts when the scan index returns to 0 from any other slot.
  assign boundary = (sel_q == '0) && (sel_prev_q != '0);

  // Scan index pipeline: sel_q follows digit_sel, sel_prev_q follows sel_q.
  always_comb begin
    sel_d      = digit_sel;
    sel_prev_d = sel_q;
  end

  // Shadow-buffer FSM: capture on handshake, promote at a frame boundary.
  always_comb begin
    sh_state_d      = sh_state_q;
    shadow_digits_d = shadow_digits_q;
    shadow_dp_d     = shadow_dp_q;
    shadow_blink_d  = shadow_blink_q;
    disp_digits_d   = disp_digits_q;
    disp_dp_d       = disp_dp_q;
    disp_blink_d    = disp_blink_q;
    load_ready      = 1'b0;
    case (sh_state_q)
      SH_EMPTY: begin
        load_ready = 1'b1;
        // A capture on a boundary cycle waits for the next boundary.
        if (load_valid) begin
          shadow_digits_d = load_digits;
          shadow_dp_d     = load_dp;
          shadow_blink_d  = load_blink;
          sh_state_d      = SH_FULL;
        end
      end
      SH_FULL: begin
        if (boundary) begin
          disp_digits_d = shadow_digits_q;
          disp_dp_d     = shadow_dp_q;
          disp_blink_d  = shadow_blink_q;
          sh_state_d    = SH_EMPTY;
        end
      end
      default: sh_state_d = SH_EMPTY;
    endcase
  end

  // Frame counter and blink phase, advanced once per frame boundary.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (boundary) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef FND_LZ_BLANK_EN
  // Leading-zero mask: a digit is blanked when it and all digits above it are 0.
  always_comb begin
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_digits_d[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_above;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Output decode. It uses the buffer and phase that take effect on this edge,
  // so digit 0 of a frame already shows the promoted value and the new phase.
  always_comb begin
    com_d        = '1;
    data_d       = 8'hFF;
    frame_done_d = boundary;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        com_d[i] = 1'b0;
        data_d   = lz_mask[i] ? 8'hFF : hex_to_seg(disp_digits_d[4*i +: 4]);
        if (disp_dp_d[i] && (!disp_blink_d[i] || !phase_d)) begin
          data_d[7] = 1'b0;
        end
      end
    end
  end

  // Scan pipeline, blink state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= '0;
      sel_prev_q   <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      com_q        <= '1;
      data_q       <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      sel_prev_q   <= sel_prev_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      com_q        <= com_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Shadow and displayed buffers; reset drops any pending shadow load.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_state_q      <= SH_EMPTY;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      shadow_blink_q  <= '0;
      disp_digits_q   <= '0;
      disp_dp_q       <= '0;
      disp_blink_q    <= '0;
    end else begin
      sh_state_q      <= sh_state_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dp_q     <= shadow_dp_d;
      shadow_blink_q  <= shadow_blink_d;
      disp_digits_q   <= disp_digits_d;
      disp_dp_q       <= disp_dp_d;
      disp_blink_q    <= disp_blink_d;
    end
  end

  assign fnd_com    = com_q;
  assign fnd_data   = data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_digit_decoder.sv
// Testbench for fnd_digit_decoder (4 digits, 3-bit scan index, 2-frame blink).
// A behavioural display model predicts every output cycle and pushes the
// expectation into a queue. Each cycle the expectation is popped and compared.
module tb_fnd_digit_decoder;

  localparam int ND = 4;
  localparam int SW = 3;
  localparam int BF = 2;

  // Clock and reset block.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [SW-1:0]   digit_sel;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_digits;
  logic [ND-1:0]   load_dp;
  logic [ND-1:0]   load_blink;
  logic [ND-1:0]   fnd_com;
  logic [7:0]      fnd_data;
  logic            frame_done;

  fnd_digit_decoder #(
    .NUM_DIGITS  (ND),
    .SEL_WIDTH   (SW),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_sel  (digit_sel),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_digits(load_digits),
    .load_dp    (load_dp),
    .load_blink (load_blink),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int scan_mode;  // 0: 0..3, 1: 0..7, 2: random, 3: hold

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: what the display shows, what is waiting, frame count.
  int m_sel, m_prev, m_nb;
  bit m_pend, m_accept;
  int disp_dig[ND];
  int sh_dig[ND];
  bit disp_dp[ND], sh_dp[ND], disp_bl[ND], sh_bl[ND];

  // Scoreboard: {fnd_com, fnd_data, frame_done, load_ready}.
  logic [13:0] exp_q[$];

  // Predict the outputs that appear after the current rising edge.
  task automatic model_edge();
    bit bnd, pend_pre, lead, lz_on, dp_on;
    bit blank[ND];
    int phase;
    logic [3:0] e_com;
    logic [7:0] e_data;
    m_accept = 0;
    if (reset) begin
      m_sel = 0; m_prev = 0; m_nb = 0; m_pend = 0;
      for (int i = 0; i < ND; i++) begin
        disp_dig[i] = 0; disp_dp[i] = 0; disp_bl[i] = 0;
      end
      exp_q.push_back({4'hF, 8'hFF, 1'b0, 1'b1});
      return;
    end
    bnd = (m_sel == 0) && (m_prev != 0);
    pend_pre = m_pend;
    if (bnd) m_nb++;
    if (bnd && pend_pre) begin
      for (int i = 0; i < ND; i++) begin
        disp_dig[i] = sh_dig[i]; disp_dp[i] = sh_dp[i]; disp_bl[i] = sh_bl[i];
      end
      m_pend = 0;
    end
    if (!pend_pre && load_valid) begin
      for (int i = 0; i < ND; i++) begin
        sh_dig[i] = int'(load_digits[4*i +: 4]);
        sh_dp[i]  = load_dp[i];
        sh_bl[i]  = load_blink[i];
      end
      m_pend = 1;
      m_accept = 1;
    end
    // Blink phase flips every BF frames counted from reset.
    phase = (m_nb / BF) % 2;
`ifdef FND_LZ_BLANK_EN
    lz_on = 1;
`else
    lz_on = 0;
`endif
    lead = 1;
    for (int i = ND - 1; i >= 0; i--) begin
      if (disp_dig[i] != 0) lead = 0;
      blank[i] = lz_on && lead && (i != 0);
    end
    e_com = 4'hF;
    e_data = 8'hFF;
    if (m_sel < ND) begin
      e_com[m_sel] = 1'b0;
      e_data = blank[m_sel] ? 8'hFF : seg_tab[disp_dig[m_sel]];
      dp_on = disp_dp[m_sel] && (!disp_bl[m_sel] || phase == 0);
      if (dp_on) e_data[7] = 1'b0;
    end
    exp_q.push_back({e_com, e_data, bnd, !m_pend});
    m_prev = m_sel;
    m_sel = int'(digit_sel);
  endtask

  task automatic check_outputs();
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty obs=0 exp=1");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (fnd_com === e[13:10]) else begin
      errors++;
      $error("FAIL fnd_com t=%0t obs=%b exp=%b", $time, fnd_com, e[13:10]);
    end
    checks++;
    assert (fnd_data === e[9:2]) else begin
      errors++;
      $error("FAIL fnd_data t=%0t obs=%h exp=%h", $time, fnd_data, e[9:2]);
    end
    checks++;
    assert (frame_done === e[1]) else begin
      errors++;
      $error("FAIL frame_done t=%0t obs=%b exp=%b", $time, frame_done, e[1]);
    end
    checks++;
    assert (load_ready === e[0]) else begin
      errors++;
      $error("FAIL load_ready t=%0t obs=%b exp=%b", $time, load_ready, e[0]);
    end
  endtask

  // One clock: predict at the edge, check 1 time unit later, then move the scan.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    case (scan_mode)
      0: digit_sel = (digit_sel >= 3'd3) ? 3'd0 : digit_sel + 3'd1;
      1: digit_sel = digit_sel + 3'd1;
      2: digit_sel = SW'($urandom_range(0, 7));
      default: digit_sel = digit_sel;
    endcase
  endtask

  // Offer one digit set and hold it until the model sees the transfer.
  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    int budget;
    budget = 200;
    load_digits = d; load_dp = dp; load_blink = bl; load_valid = 1'b1;
    do begin
      tick();
      budget--;
    end while (!m_accept && budget > 0);
    if (!m_accept) begin
      errors++;
      $error("FAIL load_timeout obs=not_accepted exp=accepted data=%h", d);
    end
    load_valid = 1'b0;
    load_digits = 16'($urandom);
    load_dp = 4'($urandom);
    load_blink = 4'($urandom);
  endtask

  initial begin
    reset = 1'b1; digit_sel = '0; load_valid = 1'b0;
    load_digits = '0; load_dp = '0; load_blink = '0;
    scan_mode = 0;

    // Reset with the scan running: outputs blank.
    repeat (6) tick();
    reset = 1'b0;
    // All zeros displayed, one frame_done per 4 cycles.
    repeat (12) tick();

    // Basic load.
    do_load(16'h1A5F, 4'b0000, 4'b0000);
    repeat (16) tick();

    // Load offered mid-frame at slot 2.
    for (int k = 0; k < 8 && digit_sel != 3'd2; k++) tick();
    do_load(16'h2468, 4'b0011, 4'b0000);
    repeat (12) tick();

    // Second offer while the shadow is full waits for promotion.
    do_load(16'h1357, 4'b1000, 4'b0000);
    do_load(16'h9BDF, 4'b0000, 4'b0000);
    repeat (12) tick();

    // Held scan index: no boundaries, so the load stays pending.
    scan_mode = 3;
    do_load(16'hCAFE, 4'b0001, 4'b0000);
    repeat (10) tick();
    scan_mode = 0;
    repeat (8) tick();

    // 3-bit scan: slots 4..7 are blank.
    scan_mode = 1;
    repeat (32) tick();
    scan_mode = 0;

    // dp blink on digit 2.
    do_load(16'h4321, 4'b0100, 4'b0100);
    repeat (48) tick();

    // Leading-zero patterns.
    do_load(16'h0007, 4'b0000, 4'b0000);
    repeat (12) tick();
    do_load(16'h0105, 4'b0010, 4'b0000);
    repeat (12) tick();
    do_load(16'h0000, 4'b0100, 4'b0000);
    repeat (12) tick();

    // Randomized scan, loads and occasional reset.
    scan_mode = 2;
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!load_valid && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b1;
        load_digits = 16'($urandom);
        load_dp = 4'($urandom);
        load_blink = 4'($urandom);
      end
      tick();
      if (m_accept) load_valid = 1'b0;
    end
    reset = 1'b0;
    load_valid = 1'b0;
    scan_mode = 0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
